// File: rtl/emulador_dht22_pkg.sv
// Shared definitions for the DHT22 sensor emulator: state codes, default
// protocol timing and the microsecond-to-cycle conversion.
package emulador_dht22_pkg;

    localparam int PERIODO_CLK_NS_PADRAO = 40;
    localparam int T_START_MIN_US_PADRAO = 800;
    localparam int T_ESPERA_US_PADRAO    = 30;
    localparam int T_RESP_US_PADRAO      = 80;
    localparam int T_BIT_BAIXO_US_PADRAO = 50;
    localparam int T_BIT0_US_PADRAO      = 26;
    localparam int T_BIT1_US_PADRAO      = 70;

    typedef enum logic [3:0] {
        S_OCIOSO     = 4'd0,
        S_START      = 4'd1,
        S_ESPERA     = 4'd2,
        S_RESP_BAIXO = 4'd3,
        S_RESP_ALTO  = 4'd4,
        S_BIT_BAIXO  = 4'd5,
        S_BIT_ALTO   = 4'd6,
        S_FIM        = 4'd7,
        S_LIBERA     = 4'd8
    } estado_t;

    function automatic logic [15:0] us_para_ciclos(input int t_us, input int periodo_ns);
        return 16'(t_us * 1000 / periodo_ns);
    endfunction

endpackage

// File: rtl/emulador_dht22_sincronizador_entrada.sv
// Two-flop synchronizer for the open-drain data line; resets to the idle
// (pulled-up) level so a reset never looks like a start pulse.
module sincronizador_entrada (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sinc_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b1;
            sinc_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sinc_q <= meta_q;
        end
    end

    assign q_o = sinc_q;

endmodule

// File: rtl/emulador_dht22.sv
// DHT22 sensor-side emulator: detects the host start pulse, answers with the
// response preamble and shifts out humidity, temperature and checksum.
module emulador_dht22
    import emulador_dht22_pkg::*;
#(
    parameter int PERIODO_CLK_NS = PERIODO_CLK_NS_PADRAO,
    parameter int T_START_MIN_US = T_START_MIN_US_PADRAO,
    parameter int T_ESPERA_US    = T_ESPERA_US_PADRAO,
    parameter int T_RESP_US      = T_RESP_US_PADRAO,
    parameter int T_BIT_BAIXO_US = T_BIT_BAIXO_US_PADRAO,
    parameter int T_BIT0_US      = T_BIT0_US_PADRAO,
    parameter int T_BIT1_US      = T_BIT1_US_PADRAO
) (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire         pino_dht,
    input  logic        habilitar,
    input  logic [15:0] umidade_in,
    input  logic [15:0] temperatura_in,
    input  logic        corromper_checksum,
    output logic        ocupado,
    output logic        transmissao_concluida,
    output logic [3:0]  estado_depuracao
);

    // Terminal counts are N-1 because the counter starts at 0 on state entry.
    localparam logic [15:0] N_START_M1 = us_para_ciclos(T_START_MIN_US, PERIODO_CLK_NS) - 16'd1;
    localparam logic [15:0] N_ESP_M1   = us_para_ciclos(T_ESPERA_US, PERIODO_CLK_NS) - 16'd1;
    localparam logic [15:0] N_RESP_M1  = us_para_ciclos(T_RESP_US, PERIODO_CLK_NS) - 16'd1;
    localparam logic [15:0] N_BL_M1    = us_para_ciclos(T_BIT_BAIXO_US, PERIODO_CLK_NS) - 16'd1;
    localparam logic [15:0] N_B0_M1    = us_para_ciclos(T_BIT0_US, PERIODO_CLK_NS) - 16'd1;
    localparam logic [15:0] N_B1_M1    = us_para_ciclos(T_BIT1_US, PERIODO_CLK_NS) - 16'd1;

    estado_t     estado_q, estado_d;
    logic [15:0] cont_q, cont_d;
    logic [39:0] quadro_q, quadro_d;
    logic [5:0]  bit_q, bit_d;
    logic        dirige_q, dirige_d;
    logic        ocupado_q, ocupado_d;
    logic        concl_q, concl_d;
    logic        linha_s;
    logic [7:0]  ck;

    sincronizador_entrada u_sinc (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .d_i       (pino_dht),
        .q_o       (linha_s)
    );

    assign ck = (umidade_in[15:8] + umidade_in[7:0] + temperatura_in[15:8] + temperatura_in[7:0])
                ^ {8{corromper_checksum}};

    always_comb begin
        estado_d  = estado_q;
        cont_d    = (cont_q == 16'hFFFF) ? cont_q : cont_q + 16'd1;
        quadro_d  = quadro_q;
        bit_d     = bit_q;
        ocupado_d = ocupado_q;
        concl_d   = 1'b0;
        case (estado_q)
            S_OCIOSO: if (habilitar && !linha_s) estado_d = S_START;
            S_START: begin
                if (linha_s) begin
                    if (cont_q >= N_START_M1) begin
                        estado_d  = S_ESPERA;
                        ocupado_d = 1'b1;
                        quadro_d  = {umidade_in, temperatura_in, ck};
                        bit_d     = 6'd0;
                    end else begin
                        estado_d = S_OCIOSO;
                    end
                end
            end
            S_ESPERA:     if (cont_q == N_ESP_M1)  estado_d = S_RESP_BAIXO;
            S_RESP_BAIXO: if (cont_q == N_RESP_M1) estado_d = S_RESP_ALTO;
            S_RESP_ALTO:  if (cont_q == N_RESP_M1) estado_d = S_BIT_BAIXO;
            S_BIT_BAIXO:  if (cont_q == N_BL_M1)   estado_d = S_BIT_ALTO;
            S_BIT_ALTO: begin
                if (cont_q == (quadro_q[39] ? N_B1_M1 : N_B0_M1)) begin
                    quadro_d = {quadro_q[38:0], 1'b0};
                    bit_d    = bit_q + 6'd1;
                    estado_d = (bit_q == 6'd39) ? S_FIM : S_BIT_BAIXO;
                end
            end
            S_FIM: if (cont_q == N_BL_M1) estado_d = S_LIBERA;
            S_LIBERA: begin
                if (linha_s) begin
                    concl_d   = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = S_OCIOSO;
                end
            end
            default: estado_d = S_OCIOSO;
        endcase
        if (estado_d != estado_q) cont_d = 16'd0;
        // Driver follows the next state so every low phase is exactly N cycles.
        dirige_d = (estado_d == S_RESP_BAIXO) || (estado_d == S_BIT_BAIXO) || (estado_d == S_FIM);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q  <= S_OCIOSO;
            cont_q    <= 16'd0;
            quadro_q  <= 40'd0;
            bit_q     <= 6'd0;
            dirige_q  <= 1'b0;
            ocupado_q <= 1'b0;
            concl_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            quadro_q  <= quadro_d;
            bit_q     <= bit_d;
            dirige_q  <= dirige_d;
            ocupado_q <= ocupado_d;
            concl_q   <= concl_d;
        end
    end

    assign pino_dht              = dirige_q ? 1'b0 : 1'bz;
    assign ocupado               = ocupado_q;
    assign transmissao_concluida = concl_q;
    assign estado_depuracao      = estado_q;

endmodule

// File: tb/tb_emulador_dht22.sv
// Self-checking bench for emulador_dht22: a host/reader model drives start
// pulses, measures line segments and decodes the frame.
module tb_emulador_dht22;

    // 1 MHz clock keeps every timing at N = T_US cycles.
    localparam int PER    = 1000;
    localparam int N_ESP  = 30 * 1000 / PER;
    localparam int N_RESP = 80 * 1000 / PER;
    localparam int N_BL   = 50 * 1000 / PER;
    localparam int N_B0   = 26 * 1000 / PER;
    localparam int N_B1   = 70 * 1000 / PER;
    localparam int N_HOST = 1000 * 1000 / PER;
    localparam int N_CURTO = 500 * 1000 / PER;
    localparam int LIMITE = 400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        habilitar = 1'b0;
    logic        host_low = 1'b0;
    logic        corr = 1'b0;
    logic [15:0] umid = 16'd0;
    logic [15:0] temp = 16'd0;
    logic        ocupado, concl;
    logic [3:0]  estado;
    wire         pino_dht;

    pullup (pino_dht);
    assign pino_dht = host_low ? 1'b0 : 1'bz;

    emulador_dht22 #(.PERIODO_CLK_NS(PER)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .pino_dht              (pino_dht),
        .habilitar             (habilitar),
        .umidade_in            (umid),
        .temperatura_in        (temp),
        .corromper_checksum    (corr),
        .ocupado               (ocupado),
        .transmissao_concluida (concl),
        .estado_depuracao      (estado)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    always @(negedge clk) if (concl) pulses <= pulses + 1;

    typedef struct {
        logic [15:0] u;
        logic [15:0] t;
        logic        c;
        logic [7:0]  ck;
    } vetor_t;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] exp);
        tests++;
        if (atual != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, exp);
        end
    endtask

    task automatic check_range(input string nome, input int atual, input int lo, input int hi);
        tests++;
        if (atual < lo || atual > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", nome, atual, lo, hi);
        end
    endtask

    function automatic logic [7:0] ck_modelo(input logic [15:0] u, input logic [15:0] t, input logic c);
        int s;
        s = (u >> 8) + (u % 256) + (t >> 8) + (t % 256);
        s = s % 256;
        if (c) s = 255 - s;
        return s[7:0];
    endfunction

    // Counts consecutive negedge samples at level lvl, starting with the current one.
    task automatic seg(input logic lvl, output int len);
        len = 1;
        while (len <= LIMITE) begin
            @(negedge clk);
            if (pino_dht != lvl) break;
            len++;
        end
    endtask

    task automatic pulso_host(input int ciclos);
        @(negedge clk);
        host_low = 1'b1;
        repeat (ciclos) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] u, input logic [15:0] t, input logic c,
                             input logic [7:0] ck, input logic drop);
        logic [39:0] rx;
        int len, base, ruins;
        umid = u; temp = t; corr = c;
        base = pulses;
        pulso_host(N_HOST);
        seg(1'b1, len); check_range("espera", len, N_ESP, N_ESP + 4);
        seg(1'b0, len); check("resp_baixo", len, N_RESP);
        check("ocupado_quadro", ocupado, 1);
        umid = ~u; temp = ~t; corr = ~c;
        seg(1'b1, len); check("resp_alto", len, N_RESP);
        ruins = 0;
        rx = 40'd0;
        for (int i = 0; i < 40; i++) begin
            if (drop && i == 10) habilitar = 1'b0;
            seg(1'b0, len);
            if (len != N_BL) ruins++;
            seg(1'b1, len);
            if (len != N_B0 && len != N_B1) ruins++;
            rx = {rx[38:0], (len == N_B1)};
        end
        check("tempo_bits", ruins, 0);
        seg(1'b0, len); check("fim_baixo", len, N_BL);
        repeat (10) @(negedge clk);
        check("quadro", rx, {u, t, ck});
        check("ck_erro", (rx[7:0] != ck_modelo(rx[39:24], rx[23:8], 1'b0)), c);
        check("pulso_concl", pulses - base, 1);
        check("ocupado_fim", ocupado, 0);
        check("estado_fim", estado, 0);
        habilitar = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic sem_resposta(input int ciclos, input string nome);
        int baixos, ocup, base;
        base = pulses;
        ocup = 0;
        @(negedge clk);
        host_low = 1'b1;
        repeat (ciclos) begin
            @(negedge clk);
            if (ocupado) ocup++;
        end
        host_low = 1'b0;
        baixos = 0;
        repeat (300) begin
            @(negedge clk);
            if (pino_dht == 1'b0) baixos++;
            if (ocupado) ocup++;
        end
        check({nome, "_linha"}, baixos, 0);
        check({nome, "_ocupado"}, ocup, 0);
        check({nome, "_estado"}, estado, 0);
        check({nome, "_pulso"}, pulses - base, 0);
    endtask

    initial begin
        vetor_t vet[3];
        logic [15:0] u, t;
        logic c;
        int k, base;

        vet[0] = '{u: 16'h028C, t: 16'h010F, c: 1'b0, ck: 8'h9E};
        vet[1] = '{u: 16'h028C, t: 16'h8065, c: 1'b0, ck: 8'h73};
        vet[2] = '{u: 16'h028C, t: 16'h8065, c: 1'b1, ck: 8'h8C};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ocupado", ocupado, 0);
        check("rst_concl", concl, 0);
        check("rst_estado", estado, 0);
        check("rst_linha", pino_dht, 1);
        reset_n = 1'b1;
        habilitar = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 3; i++) run_frame(vet[i].u, vet[i].t, vet[i].c, vet[i].ck, 1'b0);

        for (int i = 0; i < 3; i++) begin
            u = 16'($urandom);
            t = 16'($urandom);
            c = 1'($urandom_range(0, 1));
            run_frame(u, t, c, ck_modelo(u, t, c), 1'b0);
        end

        sem_resposta(N_CURTO, "start_curto");
        habilitar = 1'b0;
        sem_resposta(N_HOST, "hab_zero");
        habilitar = 1'b1;

        run_frame(16'h1234, 16'h8ABC, 1'b0, ck_modelo(16'h1234, 16'h8ABC, 1'b0), 1'b1);

        pulso_host(N_HOST);
        k = 0;
        while (estado != 4'd5 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("chegou_bit_baixo", estado, 5);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_meio_linha", pino_dht, 1);
        check("rst_meio_ocupado", ocupado, 0);
        check("rst_meio_estado", estado, 0);
        @(negedge clk);
        reset_n = 1'b1;
        base = pulses;
        repeat (200) @(negedge clk);
        check("rst_meio_sem_pulso", pulses - base, 0);

        run_frame(16'h028C, 16'h010F, 1'b0, 8'h9E, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/emulador_dht22.md
Name: emulador_dht22

Overview:
- Sensor-side emulator of the DHT22 single-wire protocol; the responder counterpart of the project's DHT22 reader.
- Watches the shared open-drain line for a host start pulse. Answers with the sensor response preamble, then sends a 40-bit frame: humidity, temperature, checksum.
- Used for on-board loopback and bench testing of the reader without a physical sensor. Frame data comes from registers or switches.

Parameters:
- PERIODO_CLK_NS, 40, clock period in ns (25 MHz); every timing below is converted to N = T_US*1000/PERIODO_CLK_NS cycles.
- T_START_MIN_US, 800, minimum host low time accepted as a valid start.
- T_ESPERA_US, 30, delay from host release to the response low.
- T_RESP_US, 80, duration of the response low phase and, separately, of the response high phase.
- T_BIT_BAIXO_US, 50, low phase preceding each bit and the end-of-frame low.
- T_BIT0_US, 26, high phase of a '0' bit.
- T_BIT1_US, 70, high phase of a '1' bit.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pino_dht  inout  1  open-drain data line; driven only to 0 or Z
- habilitar  in  1  1 = respond to start pulses
- umidade_in  in  16  humidity word to send
- temperatura_in  in  16  temperature word to send; bit 15 = sign
- corromper_checksum  in  1  1 = send the inverted checksum
- ocupado  out  1  high from start detection until return to idle
- transmissao_concluida  out  1  one-cycle pulse when the frame ends
- estado_depuracao  out  4  current FSM state code

Behaviour:
- Line driver: pino_dht = dirige_baixo ? 0 : Z. dirige_baixo is a register. Line sampling goes through a 2-FF synchronizer; all decisions use the synchronized value.
- Reset on a clk edge with reset_n=0:
  - outputs: dirige_baixo=0 (line released), ocupado=0, transmissao_concluida=0, state=S_OCIOSO (0)
  - internals: counter=0, shift register=0
- Single cycle counter, 16-bit, saturates at max, cleared on every state change.
- States and transitions:
  - S_OCIOSO(0): if habilitar and line low -> S_START (1).
  - S_START(1): counts low time. Line high before N(T_START_MIN) -> S_OCIOSO; short pulse ignored, ocupado stays 0. Line high at or after N(T_START_MIN) -> S_ESPERA (2). On that transition:
    - ocupado<=1
    - snapshot {umidade_in, temperatura_in, ck} into a 40-bit shift register
    - ck = (u[15:8]+u[7:0]+t[15:8]+t[7:0]) mod 256, XOR 8'hFF when corromper_checksum=1
  - S_ESPERA(2): line released for N(T_ESPERA) cycles -> S_RESP_BAIXO (3).
  - S_RESP_BAIXO(3): drive low N(T_RESP) cycles -> S_RESP_ALTO (4).
  - S_RESP_ALTO(4): release N(T_RESP) cycles -> S_BIT_BAIXO (5).
  - S_BIT_BAIXO(5): drive low N(T_BIT_BAIXO) cycles -> S_BIT_ALTO (6).
  - S_BIT_ALTO(6): release N(T_BIT1) cycles if shift[39]=1, else N(T_BIT0). Then shift left by 1 and increment the bit index. After bit 40 -> S_FIM (7); otherwise -> S_BIT_BAIXO.
  - S_FIM(7): drive low N(T_BIT_BAIXO) cycles, release -> S_LIBERA (8).
  - S_LIBERA(8): wait until the synchronized line is high. Then pulse transmissao_concluida, ocupado<=0, -> S_OCIOSO.
- Bit order: MSB first (humidity bit 15 first, checksum bit 0 last).
- Every low phase is exactly N cycles of dirige_baixo=1, ±0 cycles.
- Input changes after the snapshot do not affect the frame in flight.
- habilitar deasserted mid-frame: the frame completes; only new start detection is blocked.
- Host holding the line low indefinitely: stay in S_START with the counter saturated; respond after release.
- Line seen low during the emulator's own released phases (contention) is not checked; timing is purely counter-driven.
- Reset mid-frame: line released on that same edge, no completion pulse.
- estado_depuracao = state code; codes 9-15 unused.

Decomposition:
- Shared package: state encoding localparams, the us->cycles conversion function, and the default timing constants shared with the reader's timing set.
- One natural sub-module: sincronizador_entrada (2-FF synchronizer, reset value 1).
- Checksum add and frame shift register stay inline.

Test Plan:
- Nominal frame: umidade_in=16'h028C, temperatura_in=16'h010F, host low 1 ms.
  - Response: 750 cycles released, 2000 low, 2000 high.
  - Frame: 40 bits decoding to 0x028C, 0x010F, checksum 0x9E.
  - Completion: transmissao_concluida pulses once.
- Bit timing: each bit has 1250 low cycles; high is 650 cycles for '0' and 1750 for '1'. End-of-frame low is 1250 cycles, then release.
- Short start (500 us low) -> no line activity, ocupado stays 0, state returns to 0.
- Negative temperature 16'h8065 with humidity 16'h028C -> checksum 0x73. With corromper_checksum=1 -> checksum 0x8C, and the reader flags a checksum error.
- Reset asserted mid S_BIT_BAIXO -> line Z on the next edge, ocupado=0, no completion pulse. A following valid start yields a full correct frame.
- habilitar=0 during a 1 ms start -> no response. habilitar dropped during bit 10 -> the frame still completes all 40 bits.
